// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default depth, entry layout and FSM encoding.
package store_buffer_pkg;

   localparam int unsigned SbDepthDefault = 4;
   localparam int unsigned SbEntryW       = 68;

   // One buffered store; field widths sum to SbEntryW.
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } sb_entry_t;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StDrain  = 3'd1,
      StRdReq  = 3'd2,
      StRdWait = 3'd3,
      StRdDone = 3'd4
   } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Store FIFO for the store buffer.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   full_o, empty_o occupancy flags decoded from the pointers
//   multi_o         more than one entry held
//   head_o          oldest entry
//   next_o          entry behind the head (valid when multi_o)
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int unsigned Depth = SbDepthDefault
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  sb_entry_t push_data_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output logic      multi_o,
   output sb_entry_t head_o,
   output sb_entry_t next_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned PtrW  = AddrW + 1;

   logic [SbEntryW-1:0] mem_q [Depth];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PtrW-1:0]     count;
   logic [AddrW-1:0]    rd_idx_next;
   logic                do_push, do_pop;

   // Pointers carry one extra MSB so full and empty are distinguishable on equal indices.
   always_comb begin
      empty_o     = (wr_ptr_q == rd_ptr_q);
      full_o      = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
      count       = wr_ptr_q - rd_ptr_q;
      multi_o     = (count > PtrW'(1));
      rd_idx_next = rd_ptr_q[AddrW-1:0] + AddrW'(1);
      head_o      = sb_entry_t'(mem_q[rd_ptr_q[AddrW-1:0]]);
      next_o      = sb_entry_t'(mem_q[rd_idx_next]);
      do_push     = push_i && !full_o;
      do_pop      = pop_i && !empty_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   // Payload storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core data port and a single-outstanding memory interface.
// Stores are queued and drained in order; loads wait for the queue to empty, then issue
// one read and return its data through a held register. No store-to-load forwarding.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   data_sram_*                 core request (wen != 0 store, wen == 0 load) and load data
//   stallreq_for_sb             stall the core; it holds its request while high
//   mem_req/wr/wstrb/addr/wdata memory request, registered and stable while mem_req is high
//   mem_addr_ok/data_ok/rdata   memory accept, completion and read data
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SbDepthDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq_for_sb,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   sb_state_e   state_q;
   logic        mem_req_q, mem_wr_q;
   logic [3:0]  mem_wstrb_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;

   logic        is_store, is_load, push, wr_done, stall_raw;
   logic        fifo_full, fifo_empty, fifo_multi;
   sb_entry_t   in_entry, head, second, issue_entry;

   sb_fifo #(
      .Depth(DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .push_i     (push),
      .push_data_i(in_entry),
      .pop_i      (wr_done),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .multi_o    (fifo_multi),
      .head_o     (head),
      .next_o     (second)
   );

   always_comb begin
      is_store = data_sram_en && (data_sram_wen != 4'b0000);
      is_load  = data_sram_en && (data_sram_wen == 4'b0000);
      in_entry = '{addr: data_sram_addr, wstrb: data_sram_wen, wdata: data_sram_wdata};
      push     = is_store && !fifo_full && ((state_q == StIdle) || (state_q == StDrain));
      // data_ok only counts once the request has been accepted (or is accepted now).
      wr_done  = (state_q == StDrain) && mem_data_ok && (!mem_req_q || mem_addr_ok);

      // In IDLE an empty queue means the store being pushed now is the next to issue;
      // in DRAIN the entry after the one being popped is next.
      if (state_q == StIdle) begin
         issue_entry = fifo_empty ? in_entry : head;
      end else begin
         issue_entry = fifo_multi ? second : in_entry;
      end

      unique case (state_q)
         StIdle, StDrain:   stall_raw = is_load || (is_store && fifo_full);
         StRdReq, StRdWait: stall_raw = 1'b1;
         default:           stall_raw = 1'b0;
      endcase
      stallreq_for_sb = stall_raw && rst;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wstrb_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty || push) begin
                  state_q     <= StDrain;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b1;
                  mem_addr_q  <= issue_entry.addr;
                  mem_wstrb_q <= issue_entry.wstrb;
                  mem_wdata_q <= issue_entry.wdata;
               end else if (is_load) begin
                  state_q     <= StRdReq;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b0;
                  mem_addr_q  <= data_sram_addr;
                  mem_wstrb_q <= '0;
               end
            end
            StDrain: begin
               if (mem_req_q && mem_addr_ok) mem_req_q <= 1'b0;
               if (wr_done) begin
                  if (fifo_multi || push) begin
                     mem_req_q   <= 1'b1;
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= issue_entry.addr;
                     mem_wstrb_q <= issue_entry.wstrb;
                     mem_wdata_q <= issue_entry.wdata;
                  end else if (is_load) begin
                     state_q     <= StRdReq;
                     mem_req_q   <= 1'b1;
                     mem_wr_q    <= 1'b0;
                     mem_addr_q  <= data_sram_addr;
                     mem_wstrb_q <= '0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StRdReq: begin
               if (mem_addr_ok) begin
                  mem_req_q <= 1'b0;
                  if (mem_data_ok) begin
                     rdata_q <= mem_rdata;
                     state_q <= StRdDone;
                  end else begin
                     state_q <= StRdWait;
                  end
               end
            end
            StRdWait: begin
               if (mem_data_ok) begin
                  rdata_q <= mem_rdata;
                  state_q <= StRdDone;
               end
            end
            // The core still holds the completed load here; it is not re-issued.
            StRdDone: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   assign data_sram_rdata = rdata_q;
   assign mem_req         = mem_req_q;
   assign mem_wr          = mem_wr_q;
   assign mem_wstrb       = mem_wstrb_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with DEPTH=4; memory handshakes are driven by hand.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr, wdata, rdata;
   logic        stall, mem_req, mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        addr_ok, data_ok;

   int n_cmp = 0;
   int n_err = 0;

   store_buffer #(
      .DEPTH(4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_sram_en   (en),
      .data_sram_wen  (wen),
      .data_sram_addr (addr),
      .data_sram_wdata(wdata),
      .data_sram_rdata(rdata),
      .stallreq_for_sb(stall),
      .mem_req        (mem_req),
      .mem_wr         (mem_wr),
      .mem_wstrb      (mem_wstrb),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_addr_ok    (addr_ok),
      .mem_data_ok    (data_ok),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_core();
      en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic test_reset();
      idle_core();
      addr_ok = 1'b0; data_ok = 1'b0; mem_rdata = 32'h0;
      rst = 1'b0;
      #3;
      n_cmp++;
      if ({mem_req, stall, mem_wr} !== 3'b000) begin
         n_err++; $display("FAIL reset_ctrl: got req/stall/wr=%b want 000", {mem_req, stall, mem_wr});
      end
      n_cmp++;
      if (rdata !== 32'h0 || dut.state_q !== StIdle || dut.u_fifo.empty_o !== 1'b1) begin
         n_err++; $display("FAIL reset_state: got rdata=%h state=%0d empty=%b want 0/0/1",
                           rdata, dut.state_q, dut.u_fifo.empty_o);
      end
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_store();
      en = 1'b1; wen = 4'hF; addr = 32'h100; wdata = 32'hDEADBEEF; #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL st1_stall: got %b want 0", stall); end
      tick();
      idle_core(); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin
         n_err++; $display("FAIL st1_issue: got req=%b wr=%b want 1/1", mem_req, mem_wr);
      end
      n_cmp++;
      if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h100, 4'hF, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL st1_payload: got %h %h %h want 100 f deadbeef",
                           mem_addr, mem_wstrb, mem_wdata);
      end
      addr_ok = 1'b1; tick(); addr_ok = 1'b0; #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin n_err++; $display("FAIL st1_req_drop: got %b want 0", mem_req); end
      data_ok = 1'b1; tick(); data_ok = 1'b0; #1;
      n_cmp++;
      if (dut.u_fifo.empty_o !== 1'b1 || dut.state_q !== StIdle || mem_req !== 1'b0) begin
         n_err++; $display("FAIL st1_done: got empty=%b state=%0d req=%b want 1/0/0",
                           dut.u_fifo.empty_o, dut.state_q, mem_req);
      end
   endtask

   task automatic test_full_stall();
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; wen = 4'hF; addr = 32'h300 + 32'(4 * i); wdata = 32'hC0DE0000 + 32'(i); #1;
         n_cmp++;
         if (stall !== 1'b0) begin n_err++; $display("FAIL full_st%0d_stall: got %b want 0", i, stall); end
         tick();
      end
      addr = 32'h310; wdata = 32'hC0DE0004; #1;
      n_cmp++;
      if (stall !== 1'b1 || dut.u_fifo.full_o !== 1'b1) begin
         n_err++; $display("FAIL full_5th_stall: got stall=%b full=%b want 1/1", stall, dut.u_fifo.full_o);
      end
      tick();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hC0DE0000) begin
         n_err++; $display("FAIL full_head_hold: got req=%b addr=%h data=%h want 1/300/c0de0000",
                           mem_req, mem_addr, mem_wdata);
      end
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL full_dataok_stall: got %b want 1", stall); end
      tick(); data_ok = 1'b0; #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL full_accept: got stall=%b want 0", stall); end
      tick();
      idle_core();
      for (int i = 1; i < 5; i++) begin
         #1;
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h300 + 32'(4 * i) ||
             mem_wdata !== 32'hC0DE0000 + 32'(i)) begin
            n_err++; $display("FAIL full_drain%0d: got req=%b addr=%h data=%h want 1/%h/%h", i,
                              mem_req, mem_addr, mem_wdata, 32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
         end
         addr_ok = 1'b1; tick(); addr_ok = 1'b0;
         data_ok = 1'b1; tick(); data_ok = 1'b0;
      end
      #1;
      n_cmp++;
      if (dut.u_fifo.empty_o !== 1'b1 || dut.state_q !== StIdle || mem_req !== 1'b0) begin
         n_err++; $display("FAIL full_end: got empty=%b state=%0d req=%b want 1/0/0",
                           dut.u_fifo.empty_o, dut.state_q, mem_req);
      end
   endtask

   task automatic test_store_then_load();
      en = 1'b1; wen = 4'h3; addr = 32'h400; wdata = 32'h11112222; tick();
      wen = 4'hC; addr = 32'h404; wdata = 32'h33334444; tick();
      wen = 4'h0; addr = 32'h200; wdata = 32'h0; #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL ld_wait_stall: got %b want 1", stall); end
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; tick(); data_ok = 1'b0; #1;
      n_cmp++;
      if (stall !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h404) begin
         n_err++; $display("FAIL ld_second_wr: got stall=%b req=%b wr=%b addr=%h want 1/1/1/404",
                           stall, mem_req, mem_wr, mem_addr);
      end
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; tick(); data_ok = 1'b0; #1;
      n_cmp++;
      if (stall !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h200) begin
         n_err++; $display("FAIL ld_read_issue: got stall=%b req=%b wr=%b addr=%h want 1/1/0/200",
                           stall, mem_req, mem_wr, mem_addr);
      end
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; mem_rdata = 32'h12345678; #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL ld_dataok_stall: got %b want 1", stall); end
      tick(); data_ok = 1'b0; mem_rdata = 32'h0; #1;
      n_cmp++;
      if (stall !== 1'b0 || rdata !== 32'h12345678 || dut.state_q !== StRdDone) begin
         n_err++; $display("FAIL ld_done: got stall=%b rdata=%h state=%0d want 0/12345678/4",
                           stall, rdata, dut.state_q);
      end
      tick();
      idle_core(); tick(); #1;
      n_cmp++;
      if (rdata !== 32'h12345678 || mem_req !== 1'b0) begin
         n_err++; $display("FAIL ld_hold: got rdata=%h req=%b want 12345678/0", rdata, mem_req);
      end
   endtask

   task automatic test_load_delay();
      int reqs = 0;
      en = 1'b1; wen = 4'h0; addr = 32'h500; #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL dly_first_stall: got %b want 1", stall); end
      tick();
      if (mem_req === 1'b1) reqs++;
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (stall !== 1'b1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL dly_wait%0d: got stall=%b req=%b want 1/0", i, stall, mem_req);
         end
         tick();
      end
      data_ok = 1'b1; mem_rdata = 32'hA5A50001; #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL dly_dataok_stall: got %b want 1", stall); end
      tick(); data_ok = 1'b0; mem_rdata = 32'h0; #1;
      n_cmp++;
      if (stall !== 1'b0 || rdata !== 32'hA5A50001) begin
         n_err++; $display("FAIL dly_done: got stall=%b rdata=%h want 0/a5a50001", stall, rdata);
      end
      tick();
      idle_core();
      for (int i = 0; i < 4; i++) begin
         if (mem_req === 1'b1) reqs++;
         tick();
      end
      n_cmp++;
      if (reqs !== 1) begin n_err++; $display("FAIL dly_one_txn: got %0d read requests want 1", reqs); end
   endtask

   task automatic test_reset_mid();
      int late = 0;
      // Three stores buffered behind a stalled write.
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; wen = 4'hF; addr = 32'h700 + 32'(4 * i); wdata = 32'(i); tick();
      end
      idle_core(); #1;
      rst = 1'b0; #1;
      n_cmp++;
      if ({mem_req, mem_wr, stall, mem_wstrb} !== 7'b0 || {mem_addr, mem_wdata, rdata} !== 96'h0) begin
         n_err++; $display("FAIL rstq_outputs: got req=%b wr=%b stall=%b addr=%h data=%h rdata=%h want 0",
                           mem_req, mem_wr, stall, mem_addr, mem_wdata, rdata);
      end
      n_cmp++;
      if (dut.u_fifo.empty_o !== 1'b1) begin
         n_err++; $display("FAIL rstq_empty: got %b want 1", dut.u_fifo.empty_o);
      end
      tick(); rst = 1'b1;
      // Reset while a read is in RD_WAIT with the load still held.
      en = 1'b1; wen = 4'h0; addr = 32'h800; tick();
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      n_cmp++;
      if (dut.state_q !== StRdWait) begin
         n_err++; $display("FAIL rstr_setup: got state=%0d want 3", dut.state_q);
      end
      rst = 1'b0; #1;
      n_cmp++;
      if ({mem_req, stall} !== 2'b00 || mem_addr !== 32'h0 || dut.state_q !== StIdle) begin
         n_err++; $display("FAIL rstr_outputs: got req=%b stall=%b addr=%h state=%0d want 0/0/0/0",
                           mem_req, stall, mem_addr, dut.state_q);
      end
      idle_core();
      tick(); rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mem_req !== 1'b0) late++;
      end
      n_cmp++;
      if (late !== 0) begin n_err++; $display("FAIL rst_no_req: got %0d cycles with req want 0", late); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         en = 1'b1; wen = 4'(1 << (i % 4)); addr = 32'h1000 + 32'(16 * i);
         wdata = 32'hA0000000 + 32'(i); tick();
         idle_core(); #1;
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h1000 + 32'(16 * i) ||
             mem_wstrb !== 4'(1 << (i % 4)) || mem_wdata !== 32'hA0000000 + 32'(i)) begin
            n_err++; $display("FAIL wrap%0d: got req=%b addr=%h strb=%h data=%h want 1/%h/%h/%h", i,
                              mem_req, mem_addr, mem_wstrb, mem_wdata, 32'h1000 + 32'(16 * i),
                              4'(1 << (i % 4)), 32'hA0000000 + 32'(i));
         end
         addr_ok = 1'b1; tick(); addr_ok = 1'b0;
         data_ok = 1'b1; tick(); data_ok = 1'b0;
      end
      #1;
      n_cmp++;
      if (dut.u_fifo.empty_o !== 1'b1 || dut.u_fifo.wr_ptr_q !== 3'd2) begin
         n_err++; $display("FAIL wrap_ptr: got empty=%b wr_ptr=%0d want 1/2",
                           dut.u_fifo.empty_o, dut.u_fifo.wr_ptr_q);
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_full_stall();
      test_store_then_load();
      test_load_delay();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
